// File: rtl/ksa_pipe_stream.sv
// Pipelined Kogge-Stone add/subtract with valid/ready stream; latency 2 + internal banks.
// Backpressure is a global stall: every stage (bubbles included) holds while the output waits.
module ksa_pipe_stream #(
  parameter int BITS       = 64,
  parameter int LEVELS     = 6,
  parameter int PIPE_EVERY = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_a,
  input  logic [BITS-1:0]  in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);
  localparam int PE = (PIPE_EVERY > 0) ? PIPE_EVERY : 1;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic             s0_vld;
  logic             s0_cin;
  logic [BITS-1:0]  s0_a;
  logic [BITS-1:0]  s0_b;
  logic [TAG_W-1:0] s0_tag;

  // Subtraction is resolved here so the prefix tree only ever adds.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld <= 1'b0;
      s0_cin <= 1'b0;
      s0_a   <= '0;
      s0_b   <= '0;
      s0_tag <= '0;
    end else if (advance) begin
      s0_vld <= in_valid;
      s0_cin <= in_sub | in_cin;
      s0_a   <= in_a;
      s0_b   <= in_sub ? ~in_b : in_b;
      s0_tag <= in_tag;
    end
  end

  for (genvar k = 0; k <= LEVELS; k++) begin : lvl
    logic             vld;
    logic             cin;
    logic             am;
    logic             bm;
    logic [TAG_W-1:0] tag;
    logic [BITS-1:0]  p0;
    logic [BITS-1:0]  p;
    logic [BITS-1:0]  g;

    if (k == 0) begin : gen_pg
      assign vld = s0_vld;
      assign cin = s0_cin;
      assign am  = s0_a[BITS-1];
      assign bm  = s0_b[BITS-1];
      assign tag = s0_tag;
      assign p0  = s0_a ^ s0_b;
      assign p   = p0;
      // Carry-in behaves as a generate at position -1.
      assign g   = (s0_a & s0_b) | {{(BITS-1){1'b0}}, s0_cin & p0[0]};
    end else begin : gen_pfx
      localparam int D = 1 << (k - 1);
      logic [BITS-1:0] cp;
      logic [BITS-1:0] cg;

      always_comb begin
        cp = lvl[k-1].p;
        cg = lvl[k-1].g;
        for (int i = D; i < BITS; i++) begin
          cg[i] = lvl[k-1].g[i] | (lvl[k-1].p[i] & lvl[k-1].g[i-D]);
          cp[i] = lvl[k-1].p[i] & lvl[k-1].p[i-D];
        end
      end

      if (PIPE_EVERY > 0 && (k % PE) == 0 && k < LEVELS) begin : gen_bank
        logic             r_vld;
        logic             r_cin;
        logic             r_am;
        logic             r_bm;
        logic [TAG_W-1:0] r_tag;
        logic [BITS-1:0]  r_p0;
        logic [BITS-1:0]  r_p;
        logic [BITS-1:0]  r_g;

        always_ff @(posedge clk) begin
          if (rst) begin
            r_vld <= 1'b0;
          end else if (advance) begin
            r_vld <= lvl[k-1].vld;
          end
        end

        always_ff @(posedge clk) begin
          if (advance) begin
            r_cin <= lvl[k-1].cin;
            r_am  <= lvl[k-1].am;
            r_bm  <= lvl[k-1].bm;
            r_tag <= lvl[k-1].tag;
            r_p0  <= lvl[k-1].p0;
            r_p   <= cp;
            r_g   <= cg;
          end
        end

        assign vld = r_vld;
        assign cin = r_cin;
        assign am  = r_am;
        assign bm  = r_bm;
        assign tag = r_tag;
        assign p0  = r_p0;
        assign p   = r_p;
        assign g   = r_g;
      end else begin : gen_wire
        assign vld = lvl[k-1].vld;
        assign cin = lvl[k-1].cin;
        assign am  = lvl[k-1].am;
        assign bm  = lvl[k-1].bm;
        assign tag = lvl[k-1].tag;
        assign p0  = lvl[k-1].p0;
        assign p   = cp;
        assign g   = cg;
      end
    end
  end

  logic [BITS-1:0] gf;
  logic [BITS-1:0] carry;
  logic [BITS-1:0] sum_c;
  logic            ovf_c;
  logic            unused_p;

  assign gf       = lvl[LEVELS].g;
  assign carry    = {gf[BITS-2:0], lvl[LEVELS].cin};
  assign sum_c    = lvl[LEVELS].p0 ^ carry;
  // Same-sign operands producing an opposite-sign result.
  assign ovf_c    = (lvl[LEVELS].am == lvl[LEVELS].bm) && (sum_c[BITS-1] != lvl[LEVELS].am);
  assign unused_p = ^lvl[LEVELS].p;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (advance) begin
      out_valid <= lvl[LEVELS].vld;
      out_sum   <= sum_c;
      out_cout  <= gf[BITS-1];
      out_ovf   <= ovf_c;
      out_zero  <= ~|sum_c;
      out_tag   <= lvl[LEVELS].tag;
    end
  end

endmodule
